// File: rtl/uart_cmd_framer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_framer
//  Purpose  : Host-link framer between the UART and the command dispatcher.
//             RX path assembles CMD_BYTES-byte command frames from UART bytes
//             and drops a partial frame when the inter-byte gap exceeds
//             TIMEOUT_CYC clocks. TX path hands a response byte stream to the
//             UART transmitter one byte per tx_done.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             rx_data, rx_rdy          - byte from UART receiver
//             clr_rx_rdy               - pulse: byte consumed
//             cmd, cmd_rdy             - assembled frame (byte 0 in MSBs), held
//             clr_cmd_rdy              - dispatcher consumed cmd
//             frame_err                - pulse: partial frame dropped
//             resp_data, resp_vld      - response byte from dispatcher
//             resp_ack                 - pulse: response byte accepted
//             tx_data, trmt, tx_done   - UART transmitter handshake
//  Revision : 1.0  initial parametrised release
// ============================================================================
module uart_cmd_framer #(
    parameter int CMD_BYTES   = 3,
    parameter int TIMEOUT_CYC = 65535,
    parameter int TMR_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_rdy,
    output logic                   clr_rx_rdy,
    output logic [8*CMD_BYTES-1:0] cmd,
    output logic                   cmd_rdy,
    input  logic                   clr_cmd_rdy,
    output logic                   frame_err,
    input  logic [7:0]             resp_data,
    input  logic                   resp_vld,
    output logic                   resp_ack,
    output logic [7:0]             tx_data,
    output logic                   trmt,
    input  logic                   tx_done
);

    localparam int c_CMD_W = 8 * CMD_BYTES;
    localparam int c_CNT_W = $clog2(CMD_BYTES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CMD_BYTES - 1);

    typedef enum logic [1:0] {
        RX_COLLECT = 2'd0,
        RX_CLRWAIT = 2'd1,
        RX_HOLD    = 2'd2
    } rx_state_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    // ------------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------------
    rx_state_t            r_rx_state_q, w_rx_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q,      w_cnt_d;
    logic [c_CMD_W-1:0]   r_cmd_q,      w_cmd_d;
    logic                 r_cmd_rdy_q,  w_cmd_rdy_d;
    logic [c_CMD_W-1:0]   w_cmd_shift;
    logic                 w_capture;
    logic                 w_expire;
    logic                 w_clr_rx_rdy;
    logic                 w_frame_err;

    // A byte is taken only in COLLECT; CLRWAIT gives the UART a cycle to drop
    // rx_rdy and HOLD applies backpressure until the frame is consumed.
    assign w_capture = (r_rx_state_q == RX_COLLECT) && rx_rdy;

    generate
        if (CMD_BYTES > 1) begin : g_shift_multi
            assign w_cmd_shift = {r_cmd_q[c_CMD_W-9:0], rx_data};
        end else begin : g_shift_single
            assign w_cmd_shift = rx_data;
        end
    endgenerate

    // Inter-byte timer. It only runs while a partial frame is outstanding,
    // and a byte captured on the expiry cycle takes priority over the error.
    generate
        if (TIMEOUT_CYC > 0) begin : g_timer
            localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

            logic [TMR_W-1:0] r_tmr_q, w_tmr_d;
            logic             w_tmr_run;

            assign w_tmr_run = (r_rx_state_q != RX_HOLD) && (r_cnt_q != '0);
            assign w_expire  = w_tmr_run && !w_capture && (r_tmr_q == c_TMR_LAST);

            always_comb begin
                w_tmr_d = '0;
                if (w_tmr_run && !w_capture && !w_expire) begin
                    w_tmr_d = r_tmr_q + TMR_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tmr_q <= '0;
                end else begin
                    r_tmr_q <= w_tmr_d;
                end
            end
        end else begin : g_no_timer
            assign w_expire = 1'b0;
        end
    endgenerate

    always_comb begin
        w_rx_state_d = r_rx_state_q;
        w_cnt_d      = r_cnt_q;
        w_cmd_d      = r_cmd_q;
        w_cmd_rdy_d  = r_cmd_rdy_q;
        w_clr_rx_rdy = 1'b0;
        w_frame_err  = 1'b0;

        case (r_rx_state_q)
            RX_COLLECT: begin
                if (w_capture) begin
                    w_clr_rx_rdy = 1'b1;
                    w_cmd_d      = w_cmd_shift;
                    w_cnt_d      = r_cnt_q + c_CNT_W'(1);
                    if (r_cnt_q == c_CNT_LAST) begin
                        w_rx_state_d = RX_HOLD;
                        w_cmd_rdy_d  = 1'b1;
                    end else begin
                        w_rx_state_d = RX_CLRWAIT;
                    end
                end else if (w_expire) begin
                    w_cnt_d     = '0;
                    w_frame_err = 1'b1;
                end
            end

            RX_CLRWAIT: begin
                w_rx_state_d = RX_COLLECT;
                if (w_expire) begin
                    w_cnt_d     = '0;
                    w_frame_err = 1'b1;
                end
            end

            RX_HOLD: begin
                if (clr_cmd_rdy) begin
                    w_cmd_rdy_d  = 1'b0;
                    w_cnt_d      = '0;
                    w_rx_state_d = RX_COLLECT;
                end
            end

            default: begin
                w_rx_state_d = RX_COLLECT;
                w_cnt_d      = '0;
                w_cmd_rdy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state_q <= RX_COLLECT;
            r_cnt_q      <= '0;
            r_cmd_q      <= '0;
            r_cmd_rdy_q  <= 1'b0;
        end else begin
            r_rx_state_q <= w_rx_state_d;
            r_cnt_q      <= w_cnt_d;
            r_cmd_q      <= w_cmd_d;
            r_cmd_rdy_q  <= w_cmd_rdy_d;
        end
    end

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    tx_state_t  r_tx_state_q, w_tx_state_d;
    logic [7:0] r_tx_data_q,  w_tx_data_d;
    logic       w_tx_accept;

    always_comb begin
        w_tx_state_d = r_tx_state_q;
        w_tx_data_d  = r_tx_data_q;
        w_tx_accept  = 1'b0;

        case (r_tx_state_q)
            TX_IDLE: begin
                if (resp_vld) begin
                    w_tx_accept  = 1'b1;
                    w_tx_data_d  = resp_data;
                    w_tx_state_d = TX_BUSY;
                end
            end

            TX_BUSY: begin
                if (tx_done) begin
                    w_tx_state_d = TX_IDLE;
                end
            end

            default: begin
                w_tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state_q <= TX_IDLE;
            r_tx_data_q  <= '0;
        end else begin
            r_tx_state_q <= w_tx_state_d;
            r_tx_data_q  <= w_tx_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The handshake pulses are decoded from current state and inputs,
    // so they are masked while reset is asserted to keep every output at 0.
    // ------------------------------------------------------------------------
    assign clr_rx_rdy = w_clr_rx_rdy && !rst;
    assign frame_err  = w_frame_err  && !rst;
    assign cmd        = r_cmd_q;
    assign cmd_rdy    = r_cmd_rdy_q;
    assign trmt       = w_tx_accept  && !rst;
    assign resp_ack   = w_tx_accept  && !rst;
    assign tx_data    = r_tx_data_q;

endmodule
`default_nettype wire
